// File: rtl/dot_product_stream.sv
// dot_product_stream: pipelined multi-beat unsigned dot product over valid/ready streams.
// Define DOT_PRODUCT_STREAM_SAT_EN to saturate the accumulator and report overflow; default wraps.

module dot_product_lane #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] p
);
    assign p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
endmodule

module dot_product_stream #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] a_vec,
    input  logic [LANES*DATA_W-1:0] b_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        result,
    output logic                    overflow,
    output logic                    busy
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int TREE_W = PROD_W + $clog2(LANES);
    // Wide enough for the tree sum even when it is wider than the accumulator.
    localparam int SUM_W  = ((ACC_W > TREE_W) ? ACC_W : TREE_W) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [LEN_W-1:0]             len_q, len_d;
    logic [LEN_W-1:0]             cnt_q, cnt_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [LANES-1:0][PROD_W-1:0] lane_p;
    logic [LANES-1:0][PROD_W-1:0] prod_q, prod_d;
    logic                         prod_vld_q, prod_vld_d;
    logic [TREE_W-1:0]            tree_sum;
    logic                         accept;
    logic                         start_acc;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dot_product_lane #(.DATA_W(DATA_W)) u_lane (
            .a (a_vec[i*DATA_W +: DATA_W]),
            .b (b_vec[i*DATA_W +: DATA_W]),
            .p (lane_p[i])
        );
    end

    assign accept    = in_valid && (state_q == ACCUM);
    assign start_acc = start && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                len_d   = len;
                cnt_d   = '0;
                state_d = (len == '0) ? DONE : ACCUM;
            end
            ACCUM: if (accept) begin
                if ({1'b0, cnt_q} + (LEN_W+1)'(1) == {1'b0, len_q}) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            DRAIN: state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod_vld_d = accept;
        prod_d     = accept ? lane_p : prod_q;
        tree_sum   = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + TREE_W'(prod_q[i]);
        end
    end

`ifdef DOT_PRODUCT_STREAM_SAT_EN
    logic [SUM_W-1:0] acc_sum;
    logic             ovf_q, ovf_d;

    assign acc_sum = SUM_W'(acc_q) + SUM_W'(tree_sum);

    // Once clamped, any further addition re-clamps, so the accumulator stays all-ones.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (start_acc) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (prod_vld_q) begin
            if (acc_sum[SUM_W-1:ACC_W] != '0) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;
`else
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum = acc_q + ACC_W'(tree_sum);

    always_comb begin
        acc_d = acc_q;
        if (start_acc)       acc_d = '0;
        else if (prod_vld_q) acc_d = acc_sum;
    end

    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = acc_q;
endmodule

// File: tb/tb_dot_product_stream.sv
// Self-checking bench for dot_product_stream: default instance plus a 16-bit accumulator instance
// sharing stimulus, both compared to an arithmetic model of the expected dot product.
module tb_dot_product_stream;
    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int LEN_W  = 8;
    localparam int ACC_W  = 32;
    localparam int ACC_S  = 16;
`ifdef DOT_PRODUCT_STREAM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [LANES*DATA_W-1:0] a_vec = '0;
    logic [LANES*DATA_W-1:0] b_vec = '0;
    logic in_ready, out_valid, overflow, busy;
    logic [ACC_W-1:0] result;
    logic in_ready_s, out_valid_s, overflow_s, busy_s;
    logic [ACC_S-1:0] result_s;

    int n_cmp = 0;
    int n_err = 0;
    longint exp_sum = 0;

    always #5 clk = ~clk;

    dot_product_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .busy(busy)
    );

    dot_product_stream #(.ACC_W(ACC_S)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_s), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s),
        .overflow(overflow_s), .busy(busy_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint beat_sum(input logic [31:0] a, input logic [31:0] b);
        longint s = 0;
        for (int i = 0; i < LANES; i++)
            s += longint'(a[i*DATA_W +: DATA_W]) * longint'(b[i*DATA_W +: DATA_W]);
        return s;
    endfunction

    function automatic longint model_res(input longint s, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (SAT && s > mx) ? mx : (s & mx);
    endfunction

    function automatic logic model_ovf(input longint s, input int w);
        return SAT && (s > ((longint'(1) << w) - 1));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, {in_ready, in_ready_s}, 0);
        chk({tag, "_out_valid"}, {out_valid, out_valid_s}, 0);
        chk({tag, "_result"}, {result, result_s}, 0);
        chk({tag, "_overflow"}, {overflow, overflow_s}, 0);
        chk({tag, "_busy"}, {busy, busy_s}, 0);
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len = LEN_W'(l);
        exp_sum = 0;
        step();
        start = 1'b0;
        len = LEN_W'($urandom);
    endtask

    task automatic idle_beat();
        in_valid = 1'b0;
        a_vec = $urandom;
        b_vec = $urandom;
        step();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, output int waited);
        a_vec = a;
        b_vec = b;
        in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (waited >= 20) chk("beat_timeout", in_ready, 1);
        else exp_sum += beat_sum(a, b);
        step();
        in_valid = 1'b0;
        a_vec = $urandom;
        b_vec = $urandom;
    endtask

    task automatic finish_op(input string tag);
        int t = 0;
        while (out_valid !== 1'b1 && t < 40) begin
            step();
            t++;
        end
        chk({tag, "_done"}, out_valid, 1);
        chk({tag, "_res32"}, result, model_res(exp_sum, ACC_W));
        chk({tag, "_ovf32"}, overflow, model_ovf(exp_sum, ACC_W));
        chk({tag, "_res16"}, result_s, model_res(exp_sum, ACC_S));
        chk({tag, "_ovf16"}, overflow_s, model_ovf(exp_sum, ACC_S));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_ovalid"}, out_valid, 0);
    endtask

    initial begin
        int w;
        logic [ACC_W-1:0] hold;
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

        // reset
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_all_zero("post_reset");

        // single beat, latency of one edge after the accepting edge
        do_start(1);
        chk("t1_in_ready", in_ready, 1);
        send(32'h04030201, 32'h08070605, w);
        chk("t1_drain_ovalid", out_valid, 0);
        chk("t1_drain_iready", in_ready, 0);
        chk("t1_drain_busy", busy, 1);
        step();
        chk("t1_latency", out_valid, 1);
        chk("t1_res70", result, 70);
        finish_op("t1");

        // back-to-back full-scale beats
        do_start(3);
        for (int i = 0; i < 3; i++) begin
            send(32'hFFFFFFFF, 32'hFFFFFFFF, w);
            chk("t2_no_bubble", w, 0);
        end
        step();
        chk("t2_ovalid", out_valid, 1);
        chk("t2_res780300", result, 780300);
        finish_op("t2");

        // gaps in in_valid
        do_start(4);
        for (int i = 0; i < 7; i++) begin
            if (pat[i] == 1) send(32'h01010101, 32'h01010101, w);
            else idle_beat();
        end
        chk("t3_drain_iready", in_ready, 0);
        step();
        chk("t3_res16", result, 16);
        finish_op("t3");

        // back-pressure in DONE, start ignored
        do_start(2);
        send($urandom, $urandom, w);
        send($urandom, $urandom, w);
        step();
        chk("t4_ovalid", out_valid, 1);
        chk("t4_res", result, model_res(exp_sum, ACC_W));
        hold = result;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                len = 8'd7;
            end
            step();
            start = 1'b0;
            chk("t4_hold_ovalid", out_valid, 1);
            chk("t4_hold_result", result, hold);
        end
        start = 1'b1;
        len = 8'd3;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_ovalid", out_valid, 0);
        step();
        chk("t4_start_ignored", busy, 0);
        chk("t4_result_kept", result, hold);

        // 16-bit accumulator overflow
        do_start(1);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, w);
        step();
        chk("t5_res16", result_s, SAT ? 65535 : 63492);
        chk("t5_ovf16", overflow_s, SAT ? 1 : 0);
        chk("t5_res32", result, 260100);
        chk("t5_ovf32", overflow, 0);
        finish_op("t5");

        // len == 0
        do_start(0);
        chk("t6_ovalid", out_valid, 1);
        chk("t6_result", result, 0);
        chk("t6_result16", result_s, 0);
        finish_op("t6");

        // reset mid-ACCUM
        do_start(5);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, w);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, w);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t7_async");
        step();
        rst_n = 1'b1;
        step();
        chk_all_zero("t7_after");
        do_start(2);
        send($urandom, $urandom, w);
        send($urandom, $urandom, w);
        finish_op("t7_next");

        // randomized operations
        for (int op = 0; op < 25; op++) begin
            do_start($urandom_range(0, 6));
            for (int bt = 0; bt < int'(dut.len_q) && busy === 1'b1; bt++) begin
                repeat ($urandom_range(0, 2)) idle_beat();
                send($urandom, $urandom, w);
            end
            repeat ($urandom_range(0, 3)) step();
            finish_op("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dot_product_stream.md
Name: dot_product_stream

Overview:
Parametrised, pipelined, multi-beat unsigned dot-product engine for the vector datapath. It accepts LANES element pairs per beat over a valid/ready stream. It accumulates the products of a software-programmed number of beats into a wide accumulator, then presents the final sum on a valid/ready result port. It generalises the fixed 4-element combinational dot product to arbitrary vector length, lane count and width, with back-pressure on both sides.

Parameters:
DATA_W, 8, width of each unsigned vector element
LANES, 4, element pairs consumed per beat (power of two, >=1)
LEN_W, 8, width of beat-count input; max vector length = (2^LEN_W - 1) * LANES
ACC_W, 32, accumulator/result width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a new dot product; sampled only in IDLE
len  in  LEN_W  number of beats for this operation; captured when start is accepted
in_valid  in  1  beat on a_vec/b_vec is valid
in_ready  out  1  engine accepts a beat this cycle
a_vec  in  LANES*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
b_vec  in  LANES*DATA_W  same packing as a_vec
out_valid  out  1  result holds the final sum
out_ready  in  1  consumer takes the result
result  out  ACC_W  accumulated dot product
overflow  out  1  sticky per operation; see Optional Feature
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous, while rst_n=0: state IDLE, accumulator 0, beat counter 0, pipeline valid 0. All outputs 0: in_ready, out_valid, result, overflow, busy.
- Reset mid-operation discards the partial sum and any in-flight beat. No result is produced.
- States:
  - IDLE: start=1 captures len, clears accumulator and overflow. If len!=0, go to ACCUM. If len==0, go to DONE with result 0.
  - ACCUM: in_ready=1. A beat is accepted when in_valid&&in_ready. The beat counter increments per accepted beat. On the accepted beat where counter==len-1, go to DRAIN.
  - DRAIN: in_ready=0. Waits one cycle for the pipeline, then goes to DONE.
  - DONE: out_valid=1, result stable. Hold until out_valid&&out_ready, then go to IDLE. The return to IDLE and the fall of out_valid happen on the same edge.
- In-state rules:
  - start is ignored outside IDLE.
  - in_valid gaps in ACCUM are legal; the counter holds during gaps.
- Pipeline:
  - Stage 1 registers the LANES products, each 2*DATA_W wide, on the accepting edge.
  - Stage 2, on the next edge, adds the full-width adder-tree sum to the accumulator. The tree sum is 2*DATA_W+log2(LANES) bits.
- Latency: if the last beat is accepted at edge k, result is final at edge k+1 and out_valid is high from edge k+1. This gives 1 cycle in DRAIN.
- Throughput: one beat per cycle, with no bubbles between consecutive beats.
- Width rule: the tree sum is zero-extended to ACC_W+1 before addition. The sum beyond ACC_W bits is handled per Optional Feature.
- result is held in DONE until the handshake completes. After return to IDLE it keeps its last value until the next start.
- start in the same cycle as the out handshake is ignored; start is sampled in IDLE only.

Optional Feature:
Macro DOT_PRODUCT_STREAM_SAT_EN.
- Defined:
  - Any accumulation whose true sum exceeds 2^ACC_W-1 clamps the accumulator to all-ones and sets overflow=1.
  - overflow stays 1 until the next accepted start; further additions keep the accumulator at all-ones.
- Undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - overflow is tied to 0 and no compare logic is built.

Test Plan:
- Defaults, len=1, a={4,3,2,1} (lane3..0), b={8,7,6,5}: result=70 (1*5+2*6+3*7+4*8); out_valid rises one edge after the accepting edge.
- Defaults, len=3, all lanes 255 on both inputs, in_valid high every cycle: 3 beats accepted in 3 consecutive cycles; result=780300.
- len=4, in_valid toggled 1,0,0,1,1,0,1 with lane values a=b=1: only valid cycles counted; result=16; in_ready drops in DRAIN.
- out_ready held low 5 cycles in DONE: out_valid and result stable; a start pulse during that time is ignored; IDLE is reached after out_ready=1.
- ACC_W=16, len=1, all lanes 255: result=63492 and overflow=0 without macro; result=65535 and overflow=1 with DOT_PRODUCT_STREAM_SAT_EN.
- Boundary cases:
  - len=0: result=0 with out_valid high the edge after start.
  - rst_n pulsed low mid-ACCUM: all outputs 0 immediately; the next operation's result is unaffected by the discarded partial sum.
